// File: rtl/uart_rx_word_ctrl.sv
// uart_rx_word_ctrl
//   Collects the bit stream from the UART bit receiver into bytes, then into
//   WORD_BYTES-wide words, and presents each word on a valid/ready handshake.
//   Bits arrive LSB-first. The first received bit ends up in word_data[0].
//
// Optional feature (macro UART_RX_WORD_TIMEOUT_EN):
//   When defined, an inter-bit timeout counts baud_tick while a word is
//   partially collected. When it expires, the partial word is dropped and
//   frame_err and rx_rst each pulse for one cycle.
//   When undefined, frame_err and rx_rst are tied low and a partial word
//   waits indefinitely.
//
// Ports
//   clk, rst     : system clock, asynchronous active-high reset
//   baud_tick    : 16x baud strobe (timeout time base)
//   bit_ready    : one-cycle pulse; bit_data valid in the same cycle
//   bit_data     : received bit
//   word_ready   : consumer accepts word
//   overrun_clr  : clears sticky overrun
//   word_valid   : word_data holds a complete word
//   word_data    : assembled word, first byte in the least-significant byte
//   byte_done    : one-cycle pulse after each completed byte
//   rx_rst       : one-cycle reset pulse to the bit receiver
//   frame_err    : one-cycle pulse when a partial word is dropped
//   overrun      : sticky; a bit arrived while a word was held
//   busy         : high in COLLECT or HOLD
module uart_rx_word_ctrl #(
  parameter int WORD_BYTES    = 4,
  parameter int TIMEOUT_TICKS = 480
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    baud_tick,
  input  logic                    bit_ready,
  input  logic                    bit_data,
  input  logic                    word_ready,
  input  logic                    overrun_clr,
  output logic                    word_valid,
  output logic [8*WORD_BYTES-1:0] word_data,
  output logic                    byte_done,
  output logic                    rx_rst,
  output logic                    frame_err,
  output logic                    overrun,
  output logic                    busy
);

  localparam int WW = 8 * WORD_BYTES;
  localparam int CW = $clog2(WW + 1);
  localparam logic [CW-1:0] LAST = CW'(WW - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

  state_t          state, nxt_state;
  logic [CW-1:0]   cnt, nxt_cnt;
  logic [WW-1:0]   sr;
  logic            shift_en, ovr_set, byte_set, xfer, timeout_hit;

  assign word_valid = (state == HOLD);
  assign busy       = (state != IDLE);
  assign word_data  = sr;
  assign xfer       = word_valid & word_ready;

  // A byte completes whenever an accepted bit leaves the count on a multiple
  // of 8; the word-complete wrap to 0 counts as one too.
  assign byte_set = shift_en & (nxt_cnt[2:0] == 3'd0);

  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    shift_en  = 1'b0;
    ovr_set   = 1'b0;
    case (state)
      IDLE: begin
        if (bit_ready) begin
          shift_en  = 1'b1;
          nxt_cnt   = CW'(1);
          nxt_state = COLLECT;
        end
      end
      COLLECT: begin
        // A bit always beats a coincident timeout.
        if (bit_ready) begin
          shift_en = 1'b1;
          if (cnt == LAST) begin
            nxt_cnt   = '0;
            nxt_state = HOLD;
          end else begin
            nxt_cnt = cnt + CW'(1);
          end
        end else if (timeout_hit) begin
          nxt_cnt   = '0;
          nxt_state = IDLE;
        end
      end
      HOLD: begin
        if (xfer) begin
          // A bit arriving with the transfer starts the next word.
          if (bit_ready) begin
            shift_en  = 1'b1;
            nxt_cnt   = CW'(1);
            nxt_state = COLLECT;
          end else begin
            nxt_state = IDLE;
          end
        end else if (bit_ready) begin
          // Word is held; the bit is dropped and flagged.
          ovr_set = 1'b1;
        end
      end
      default: begin
        nxt_state = IDLE;
        nxt_cnt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      sr        <= '0;
      byte_done <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= nxt_state;
      cnt       <= nxt_cnt;
      byte_done <= byte_set;
      if (shift_en) sr <= {bit_data, sr[WW-1:1]};
      // Set wins over a coincident clear.
      if (ovr_set)          overrun <= 1'b1;
      else if (overrun_clr) overrun <= 1'b0;
    end
  end

`ifdef UART_RX_WORD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_TICKS);

  logic [TW-1:0] tcnt;

  assign timeout_hit = (state == COLLECT) && !bit_ready && (tcnt == TMAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt      <= '0;
      frame_err <= 1'b0;
      rx_rst    <= 1'b0;
    end else begin
      frame_err <= timeout_hit;
      rx_rst    <= timeout_hit;
      // Every entry into COLLECT comes with a bit_ready, so clearing outside
      // COLLECT and on each bit also covers the state-entry clear.
      if (state != COLLECT || bit_ready || timeout_hit)
        tcnt <= '0;
      else if (baud_tick && tcnt != TMAX)
        tcnt <= tcnt + TW'(1);
    end
  end
`else
  logic unused_baud_tick;
  assign unused_baud_tick = baud_tick;
  assign timeout_hit      = 1'b0;
  assign frame_err        = 1'b0;
  assign rx_rst           = 1'b0;
`endif

endmodule
